frame_reader: RTL and testbench
===============================

FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter HDISP, default 800, meaning active pixels per line (one 32-bit word per pixel).
REQ-002 Parameter VDISP, default 480, meaning active lines per frame.
REQ-003 Parameter BURST_LEN, default 8, meaning maximum beats per Wishbone burst (power of two, 1..64).
REQ-004 Parameter FIFO_AW, default 8, meaning address width of the downstream FIFO; fifo_free is FIFO_AW+1 bits.
REQ-005 Port clk  input  1  sole clock of the block; one clock, reset is asynchronous and active-low.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port enable  input  1  level; when high the block fetches frames continuously.
REQ-008 Port base_addr  input  32  byte address of frame buffer A; sampled at each frame start.
REQ-009 Port resync  input  1  single-cycle pulse; restart fetching at pixel (0,0).
REQ-010 Port wshb_ifm  wshb_if.master  --  Wishbone master (adr, dat_sm, ack, cyc, stb, we, sel, cti, bte).
REQ-011 Port fifo_free  input  FIFO_AW+1  free word count of the downstream FIFO.
REQ-012 Port fifo_write  output  1  FIFO write strobe.
REQ-013 Port fifo_wdata  output  32  FIFO write data.
REQ-014 Port frame_done  output  1  one-cycle pulse after the last word of a frame is written.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT_SPACE, BURST, FRAME_END.
REQ-016 IDLE -> WAIT_SPACE when enable=1; the word pointer loads 0 and the frame base loads base_addr.
REQ-017 WAIT_SPACE -> BURST when fifo_free >= current burst length; otherwise hold with cyc=0, stb=0.
REQ-018 Current burst length SHALL be min(BURST_LEN, words remaining in frame), so the last burst of a frame may be shorter.
REQ-019 In BURST: cyc=1, stb=1, we=0, sel=4'b1111, bte=2'b00; cti=3'b010 on every beat except the last, and cti=3'b111 on the last beat.
REQ-020 adr SHALL equal frame base + 4*word pointer; the pointer increments on each ack.
REQ-021 fifo_write SHALL equal ack while in BURST, and fifo_wdata SHALL equal dat_sm, with zero-cycle latency.
REQ-022 After the last-beat ack: -> FRAME_END if the pointer has reached HDISP*VDISP; else -> WAIT_SPACE if enable=1; else -> IDLE.
REQ-023 FRAME_END SHALL pulse frame_done for exactly one cycle, reload the pointer to 0 and resample base_addr, then go -> WAIT_SPACE if enable=1, else -> IDLE.
REQ-024 A burst in progress SHALL never be aborted; a resync or enable drop takes effect only after the last-beat ack.
REQ-025 When resync is received during BURST, it SHALL be latched; after the burst the block reloads pointer 0 and base_addr without pulsing frame_done.
REQ-026 When resync is received in IDLE or WAIT_SPACE, the pointer SHALL be reset in the next cycle.
REQ-027 Pointer width SHALL be clog2(HDISP*VDISP+1); address arithmetic SHALL be 32-bit, and address wrap-around is the caller's responsibility.

Reset
REQ-028 On rst_n low, the block SHALL asynchronously force state IDLE, cyc=0, stb=0, fifo_write=0, frame_done=0, pointer 0, resync latch 0 and cti=3'b000.
REQ-029 Reset de-assertion SHALL be synchronised internally with a two-flop synchroniser before it reaches the FSM.

Configuration
REQ-030 With macro FRAME_READER_DOUBLE_BUF_EN defined, the block SHALL add the following ports:
- base_addr_b  input  32
- swap_req  input  1 (pulse)
- active_buf  output  1
REQ-031 With FRAME_READER_DOUBLE_BUF_EN defined, swap_req SHALL be latched; at the next FRAME_END, active_buf toggles and the frame base loads base_addr_b when active_buf=1, or base_addr when active_buf=0; reset value of active_buf is 0.
REQ-032 Without the macro, those ports SHALL be absent and the block SHALL always use base_addr.

Structure
REQ-033 A shared package frame_reader_pkg SHALL hold the FSM state enum and the CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010 and CTI_EOB=3'b111.
REQ-034 One sub-module, rst_sync, SHALL implement the reset synchroniser; everything else stays in frame_reader.

Verification
REQ-035 Scenario: HDISP=16, VDISP=2, BURST_LEN=8, fifo_free=256, and a slave acking every cycle -> 4 bursts at adr 0x00, 0x20, 0x40 and 0x60, each with cti 010x7 then 111, and frame_done 1 cycle after the 32nd write.
REQ-036 Scenario: HDISP=10, VDISP=1, BURST_LEN=8 -> bursts of 8 then 2 beats, with the second burst starting at adr 0x20.
REQ-037 Scenario: fifo_free=5 with BURST_LEN=8 -> cyc stays 0; raising fifo_free to 8 -> cyc asserts the next cycle.
REQ-038 Scenario: resync pulsed on the 3rd beat of a burst, with base_addr=0x1000 -> the burst completes, the next adr is 0x1000, and no frame_done pulse occurs.
REQ-039 Scenario: rst_n dropped mid-burst -> cyc, stb and fifo_write are 0 in the same cycle, without waiting for a clock edge.
REQ-040 Scenario (macro defined): base_addr=0, base_addr_b=0x8000, swap_req pulsed mid-frame -> after frame_done, active_buf=1 and the first adr is 0x8000.

Source files
------------

// File: rtl/frame_reader_pkg.sv
// frame_reader_pkg
//   Shared definitions for the frame reader: FSM state encoding, Wishbone
//   cycle-type (CTI) constants and a small elaboration-time helper.
package frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    BURST      = 2'd2,
    FRAME_END  = 2'd3
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// wshb_if
//   Wishbone B4 read-burst bundle used by the frame reader.
//   master modport: drives adr/cyc/stb/we/sel/cti/bte, receives dat_sm/ack.
//   slave modport : the mirror image.
interface wshb_if;
  logic [31:0] adr;
  logic [31:0] dat_sm;
  logic        ack;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  modport master (
    output adr, cyc, stb, we, sel, cti, bte,
    input  dat_sm, ack
  );

  modport slave (
    input  adr, cyc, stb, we, sel, cti, bte,
    output dat_sm, ack
  );
endinterface

// File: rtl/frame_reader_rst_sync.sv
// rst_sync
//   Two-flop reset synchroniser: assertion is asynchronous, de-assertion is
//   released to the clock domain after two rising edges.
//   clk        : destination clock
//   rst_n      : raw asynchronous active-low reset
//   rst_n_sync : active-low reset, asserted asynchronously, released synchronously
module rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_n_sync = sync_q[1];

endmodule

// File: rtl/frame_reader.sv
// frame_reader
//   Fetches a frame buffer (HDISP x VDISP 32-bit pixels) over Wishbone using
//   incrementing bursts and pushes every returned word into a downstream FIFO.
//   A burst is only issued once the FIFO has room for all of its beats.
//
//   Ports
//     clk, rst_n      : clock, asynchronous active-low reset
//     enable          : keep fetching frames while high
//     base_addr       : byte address of frame buffer A, sampled at frame start
//     resync          : pulse, restart fetching at pixel (0,0)
//     wshb_ifm        : Wishbone master (read-only bursts)
//     fifo_free       : free word count of the downstream FIFO
//     fifo_write      : FIFO write strobe (same cycle as ack)
//     fifo_wdata      : FIFO write data (dat_sm passed straight through)
//     frame_done      : one-cycle pulse once the last word of a frame is written
//
//   Build option FRAME_READER_DOUBLE_BUF_EN adds a second buffer:
//     base_addr_b     : byte address of frame buffer B
//     swap_req        : pulse, switch buffers at the next frame boundary
//     active_buf      : buffer currently being read (0 = A, 1 = B)
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int HDISP     = 800,
  parameter int VDISP     = 480,
  parameter int BURST_LEN = 8,
  parameter int FIFO_AW   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [31:0]        base_addr,
  input  logic               resync,
  wshb_if.master             wshb_ifm,
  input  logic [FIFO_AW:0]   fifo_free,
  output logic               fifo_write,
  output logic [31:0]        fifo_wdata,
  output logic               frame_done
`ifdef FRAME_READER_DOUBLE_BUF_EN
  ,
  input  logic [31:0]        base_addr_b,
  input  logic               swap_req,
  output logic               active_buf
`endif
);

  localparam int TOTAL = HDISP * VDISP;
  localparam int PW    = $clog2(TOTAL + 1);
  // Common width for burst-length / free-space arithmetic so that the
  // comparisons never truncate whichever operand happens to be widest.
  localparam int CW    = max_int(max_int(PW, $clog2(BURST_LEN + 1)), FIFO_AW + 1) + 1;

  logic          rst_n_sync;
  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_inc;
  logic [31:0]   frame_base;
  logic          resync_pend;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] remaining;
  logic [CW-1:0] blen;
  logic          last_beat;
  logic          cyc_q;
  logic          stb_q;
  logic [2:0]    cti_q;
  logic [31:0]   sel_base;   // base for restarts inside the current buffer
  logic [31:0]   fe_base;    // base taken at a frame boundary

  rst_sync u_rst_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_n_sync (rst_n_sync)
  );

`ifdef FRAME_READER_DOUBLE_BUF_EN
  logic swap_pend;
  logic act_q;

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      swap_pend <= 1'b0;
      act_q     <= 1'b0;
    end else if (state == FRAME_END) begin
      if (swap_pend || swap_req) begin
        act_q <= ~act_q;
      end
      swap_pend <= 1'b0;
    end else if (swap_req) begin
      swap_pend <= 1'b1;
    end
  end

  // At the frame boundary the toggle and the base reload happen on the same
  // edge, so the new base is chosen from the post-toggle buffer index.
  always_comb begin
    sel_base = act_q ? base_addr_b : base_addr;
    fe_base  = (act_q ^ (swap_pend | swap_req)) ? base_addr_b : base_addr;
  end

  assign active_buf = act_q;
`else
  always_comb begin
    sel_base = base_addr;
    fe_base  = base_addr;
  end
`endif

  always_comb begin
    remaining = CW'(TOTAL) - CW'(ptr);
    blen      = (remaining < CW'(BURST_LEN)) ? remaining : CW'(BURST_LEN);
    ptr_inc   = ptr + PW'(1);
    last_beat = (beat_cnt == CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state       <= IDLE;
      ptr         <= '0;
      frame_base  <= '0;
      resync_pend <= 1'b0;
      beat_cnt    <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      cti_q       <= CTI_CLASSIC;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable || resync) begin
            ptr        <= '0;
            frame_base <= sel_base;
          end
          if (enable) begin
            state <= WAIT_SPACE;
          end
        end

        WAIT_SPACE: begin
          if (resync) begin
            ptr        <= '0;
            frame_base <= sel_base;
          end else if (CW'(fifo_free) >= blen) begin
            state    <= BURST;
            cyc_q    <= 1'b1;
            stb_q    <= 1'b1;
            beat_cnt <= blen;
            cti_q    <= (blen == CW'(1)) ? CTI_EOB : CTI_INCR;
          end
        end

        BURST: begin
          // The burst always runs to completion; resync is only recorded here.
          if (resync) begin
            resync_pend <= 1'b1;
          end
          if (wshb_ifm.ack) begin
            ptr      <= ptr_inc;
            beat_cnt <= beat_cnt - CW'(1);
            if (beat_cnt == CW'(2)) begin
              cti_q <= CTI_EOB;
            end
            if (last_beat) begin
              cyc_q       <= 1'b0;
              stb_q       <= 1'b0;
              cti_q       <= CTI_CLASSIC;
              resync_pend <= 1'b0;
              if (resync_pend || resync) begin
                ptr        <= '0;
                frame_base <= sel_base;
                state      <= enable ? WAIT_SPACE : IDLE;
              end else if (ptr_inc == PW'(TOTAL)) begin
                state      <= FRAME_END;
                frame_done <= 1'b1;
              end else begin
                state <= enable ? WAIT_SPACE : IDLE;
              end
            end
          end
        end

        FRAME_END: begin
          ptr        <= '0;
          frame_base <= fe_base;
          state      <= enable ? WAIT_SPACE : IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign wshb_ifm.adr = frame_base + (32'(ptr) << 2);
  assign wshb_ifm.cyc = cyc_q;
  assign wshb_ifm.stb = stb_q;
  assign wshb_ifm.we  = 1'b0;
  assign wshb_ifm.sel = '1;
  assign wshb_ifm.cti = cti_q;
  assign wshb_ifm.bte = '0;

  assign fifo_write = (state == BURST) & wshb_ifm.ack;
  assign fifo_wdata = wshb_ifm.dat_sm;

endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader
//   Randomised bench for frame_reader with a word-level reference model:
//   word k of a frame lives at base + 4*k, bursts start at multiples of
//   BURST_LEN and the last beat of each burst carries cti 111.
module tb_frame_reader;

  localparam int H     = 10;
  localparam int V     = 2;
  localparam int BL    = 8;
  localparam int FAW   = 8;
  localparam int TOTAL = H * V;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           resync = 1'b0;
  logic [31:0]    base_addr = '0;
  logic [FAW:0]   fifo_free = '0;
  logic           fifo_write;
  logic [31:0]    fifo_wdata;
  logic           frame_done;
  logic [31:0]    base_addr_b = '0;
  logic           swap_req = 1'b0;
`ifdef FRAME_READER_DOUBLE_BUF_EN
  logic           active_buf;
`endif

  wshb_if bus ();

  frame_reader #(
    .HDISP     (H),
    .VDISP     (V),
    .BURST_LEN (BL),
    .FIFO_AW   (FAW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .base_addr  (base_addr),
    .resync     (resync),
    .wshb_ifm   (bus),
    .fifo_free  (fifo_free),
    .fifo_write (fifo_write),
    .fifo_wdata (fifo_wdata),
    .frame_done (frame_done)
`ifdef FRAME_READER_DOUBLE_BUF_EN
    ,
    .base_addr_b (base_addr_b),
    .swap_req    (swap_req),
    .active_buf  (active_buf)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          k = 0;
  logic [31:0] fbase = '0;
  bit          exp_done = 1'b0;
  bit          resync_pend = 1'b0;
  bit          prev_cyc = 1'b0;
  int          prev_free = 0;
  int          frames_seen = 0;
  bit          act = 1'b0;
  bit          swap_pend = 1'b0;

  function automatic int blen_of(input int kk);
    return ((TOTAL - kk) < BL) ? (TOTAL - kk) : BL;
  endfunction

  function automatic bit is_last(input int kk);
    return ((kk % BL) == BL - 1) || (kk == TOTAL - 1);
  endfunction

  task automatic restart(input bit a);
    k     = 0;
    fbase = a ? base_addr_b : base_addr;
  endtask

  // One clock cycle: entered and left on a falling edge.
  task automatic tick(input int ack_pct, input int free_val, input bit rs);
    bit          last;
    logic [31:0] want_adr;
    logic [2:0]  want_cti;
    checks++;
    if (frame_done !== exp_done) begin
      errors++;
      $display("FAIL frame_done got %0b want %0b (k=%0d)", frame_done, exp_done, k);
    end
`ifdef FRAME_READER_DOUBLE_BUF_EN
    checks++;
    if (active_buf !== act) begin
      errors++;
      $display("FAIL active_buf got %0b want %0b", active_buf, act);
    end
`endif
    if (exp_done && swap_pend) begin
      act       = ~act;
      swap_pend = 1'b0;
    end
    exp_done = 1'b0;
    if (swap_req) swap_pend = 1'b1;
    if (bus.cyc === 1'b1 && !prev_cyc) begin
      checks++;
      if (prev_free < blen_of(k)) begin
        errors++;
        $display("FAIL burst_space got free %0d want >= %0d", prev_free, blen_of(k));
      end
      checks++;
      if (bus.adr !== fbase + 4 * k) begin
        errors++;
        $display("FAIL burst_start_adr got %h want %h", bus.adr, fbase + 4 * k);
      end
    end
    prev_cyc    = (bus.cyc === 1'b1);
    fifo_free   = free_val[FAW:0];
    prev_free   = free_val;
    resync      = rs;
    bus.ack     = (bus.cyc === 1'b1) && (int'($urandom_range(99)) < ack_pct);
    bus.dat_sm  = $urandom;
    #1;
    checks++;
    if (fifo_write !== bus.ack) begin
      errors++;
      $display("FAIL fifo_write got %0b want %0b", fifo_write, bus.ack);
    end
    if (rs && bus.cyc !== 1'b1) restart(act);
    if (rs && bus.cyc === 1'b1) resync_pend = 1'b1;
    if (bus.ack) begin
      want_adr = fbase + 4 * k;
      last     = is_last(k);
      want_cti = last ? 3'b111 : 3'b010;
      checks++;
      if (bus.adr !== want_adr) begin
        errors++;
        $display("FAIL beat_adr got %h want %h (k=%0d)", bus.adr, want_adr, k);
      end
      checks++;
      if (bus.cti !== want_cti) begin
        errors++;
        $display("FAIL beat_cti got %b want %b (k=%0d)", bus.cti, want_cti, k);
      end
      checks++;
      if (fifo_wdata !== bus.dat_sm) begin
        errors++;
        $display("FAIL fifo_wdata got %h want %h", fifo_wdata, bus.dat_sm);
      end
      checks++;
      if ({bus.stb, bus.we, bus.sel, bus.bte} !== 8'b1_0_1111_00) begin
        errors++;
        $display("FAIL bus_ctrl got %b want 10111100", {bus.stb, bus.we, bus.sel, bus.bte});
      end
      k++;
      if (last) begin
        if (resync_pend) begin
          resync_pend = 1'b0;
          restart(act);
        end else if (k == TOTAL) begin
          exp_done = 1'b1;
          frames_seen++;
          restart(act ^ swap_pend);
        end else if (!enable) begin
          restart(act);
        end
      end
    end
    @(negedge clk);
  endtask

  // Bring the DUT to a non-burst cycle and restart the frame from a new base.
  task automatic resync_to(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (bus.cyc === 1'b1 && n < 50) begin
      tick(100, 256, 1'b0);
      n++;
    end
    base_addr   = a;
    base_addr_b = b;
    tick(100, 256, 1'b1);
  endtask

  task automatic test_reset;
    bus.ack    = 1'b0;
    bus.dat_sm = '0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b want 0", bus.cyc); end
    checks++;
    if (bus.stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", bus.stb); end
    checks++;
    if (fifo_write !== 1'b0) begin errors++; $display("FAIL reset_fifo_write got %b want 0", fifo_write); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    checks++;
    if (bus.cti !== 3'b000) begin errors++; $display("FAIL reset_cti got %b want 000", bus.cti); end
    rst_n = 1'b1;
    repeat (4) tick(100, 256, 1'b0);
    checks++;
    if (bus.cyc !== 1'b0) begin errors++; $display("FAIL idle_cyc got %b want 0", bus.cyc); end
  endtask

  task automatic test_wait_space;
    enable    = 1'b1;
    base_addr = '0;
    restart(act);
    repeat (10) begin
      tick(100, 5, 1'b0);
      checks++;
      if (bus.cyc !== 1'b0) begin errors++; $display("FAIL wait_space_cyc got %b want 0", bus.cyc); end
    end
    tick(100, 8, 1'b0);
    checks++;
    if (bus.cyc !== 1'b1) begin errors++; $display("FAIL space_cyc_rise got %b want 1", bus.cyc); end
  endtask

  task automatic test_full_frame;
    int target = frames_seen + 2;
    int n = 0;
    while (frames_seen < target && n < 400) begin
      tick(100, 256, 1'b0);
      n++;
    end
    checks++;
    if (frames_seen < target) begin
      errors++;
      $display("FAIL full_frame_timeout got %0d frames want %0d", frames_seen, target);
    end
    repeat (2) tick(100, 256, 1'b0);
  endtask

  task automatic test_resync;
    int n = 0;
    enable = 1'b1;
    resync_to(32'h0, 32'h0);
    while (!(bus.cyc === 1'b1 && (k % BL) == 2) && n < 100) begin
      tick(100, 256, 1'b0);
      n++;
    end
    base_addr = 32'h1000;
    tick(100, 256, 1'b1);
    n = 0;
    while (bus.cyc === 1'b1 && n < 20) begin tick(100, 256, 1'b0); n++; end
    while (bus.cyc !== 1'b1 && n < 40) begin tick(100, 256, 1'b0); n++; end
    checks++;
    if (bus.adr !== 32'h1000) begin
      errors++;
      $display("FAIL resync_adr got %h want 00001000", bus.adr);
    end
  endtask

  task automatic test_random;
    int r;
    bit rs;
    enable = 1'b1;
    resync_to($urandom & 32'h00FF_FFF0, 32'h0);
    for (int i = 0; i < 1500; i++) begin
      r  = int'($urandom_range(99));
      rs = (r < 2);
      if (r >= 2 && r < 5) enable = ~enable;
      tick(60, int'($urandom_range(12)), rs);
    end
    enable = 1'b1;
    repeat (5) tick(60, 10, 1'b0);
  endtask

  task automatic test_disable;
    enable = 1'b0;
    repeat (40) tick(100, 256, 1'b0);
    repeat (10) begin
      tick(100, 256, 1'b0);
      checks++;
      if (bus.cyc !== 1'b0) begin errors++; $display("FAIL disabled_cyc got %b want 0", bus.cyc); end
    end
  endtask

  task automatic test_async_reset;
    int n = 0;
    enable = 1'b1;
    while (bus.cyc !== 1'b1 && n < 50) begin
      tick(0, 256, 1'b0);
      n++;
    end
    checks++;
    if (bus.cyc !== 1'b1) begin errors++; $display("FAIL async_setup_timeout got %b want 1", bus.cyc); end
    bus.ack = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cyc, bus.stb, fifo_write} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset got %b want 000", {bus.cyc, bus.stb, fifo_write});
    end
    bus.ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    act         = 1'b0;
    swap_pend   = 1'b0;
    resync_pend = 1'b0;
    exp_done    = 1'b0;
    prev_cyc    = 1'b0;
    restart(act);
    repeat (60) tick(100, 256, 1'b0);
  endtask

`ifdef FRAME_READER_DOUBLE_BUF_EN
  task automatic test_swap;
    int n = 0;
    int target;
    enable = 1'b1;
    resync_to(32'h0, 32'h8000);
    while (!(bus.cyc === 1'b1 && k == 5) && n < 100) begin tick(100, 256, 1'b0); n++; end
    swap_req = 1'b1;
    tick(100, 256, 1'b0);
    swap_req = 1'b0;
    target = frames_seen + 1;
    n = 0;
    while (frames_seen < target && n < 100) begin tick(100, 256, 1'b0); n++; end
    tick(100, 256, 1'b0);
    checks++;
    if (active_buf !== 1'b1) begin errors++; $display("FAIL swap_active got %b want 1", active_buf); end
    n = 0;
    while (bus.cyc !== 1'b1 && n < 20) begin tick(100, 256, 1'b0); n++; end
    checks++;
    if (bus.adr !== 32'h8000) begin errors++; $display("FAIL swap_adr got %h want 00008000", bus.adr); end
  endtask
`endif

  initial begin
    test_reset;
    test_wait_space;
    test_full_frame;
    test_resync;
    test_random;
    test_disable;
    test_async_reset;
`ifdef FRAME_READER_DOUBLE_BUF_EN
    test_swap;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
